// File: rtl/tap_controller_if.sv
// JTAG pin bundle plus the boundary-scan chain control lines of the TAP.
// master drives the pins and returns the chain output; slave is the controller.
interface tap_controller_if;
  logic tms;
  logic tdi;
  logic tdo;
  logic tdo_en;
  logic bsr_tdi;
  logic bsr_capture;
  logic bsr_shift;
  logic bsr_update;
  logic bsr_mode;
  logic bsr_tdo;

  modport master (
    output tms, tdi, bsr_tdo,
    input  tdo, tdo_en, bsr_tdi, bsr_capture, bsr_shift, bsr_update, bsr_mode
  );

  modport slave (
    input  tms, tdi, bsr_tdo,
    output tdo, tdo_en, bsr_tdi, bsr_capture, bsr_shift, bsr_update, bsr_mode
  );
endinterface

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state FSM, instruction register and decode,
// bypass and IDCODE data registers, BSR chain strobes and a falling-edge TDO.
module tap_controller #(
  parameter int unsigned     IR_W       = 4,
  parameter logic [31:0]     IDCODE_VAL = 32'h1000_0001,
  parameter logic [IR_W-1:0] OP_EXTEST  = IR_W'(0),
  parameter logic [IR_W-1:0] OP_SAMPLE  = IR_W'(1),
  parameter logic [IR_W-1:0] OP_IDCODE  = IR_W'(2)
) (
  input  logic           tck,
  input  logic           trst,
  tap_controller_if.slave tap
);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_state_e;

  // Captured IR pattern: trailing "01" lets a host find the IR boundary.
  localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(1);

  tap_state_e      state_q, state_d;
  logic [IR_W-1:0] ir_shift_q, ir_shift_d;
  logic [IR_W-1:0] instr_q, instr_d;
  logic            mode_q, mode_d;
  logic            bypass_q, bypass_d;
  logic [31:0]     idcode_q, idcode_d;
  logic            tdo_q, tdo_d;
  logic            tdo_en_q, tdo_en_d;

  logic            sel_bsr;
  logic            sel_id;
  logic            sel_byp;

  // Instruction decode; anything not explicitly defined behaves as BYPASS.
  always_comb begin
    sel_bsr = (instr_q == OP_EXTEST) || (instr_q == OP_SAMPLE);
    sel_id  = (instr_q == OP_IDCODE);
    sel_byp = !sel_bsr && !sel_id;
  end

  // TAP state transitions driven by tms.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:     state_d = tap.tms ? TLR    : RTI;
      RTI:     state_d = tap.tms ? SEL_DR : RTI;
      SEL_DR:  state_d = tap.tms ? SEL_IR : CAP_DR;
      CAP_DR:  state_d = tap.tms ? EX1_DR : SH_DR;
      SH_DR:   state_d = tap.tms ? EX1_DR : SH_DR;
      EX1_DR:  state_d = tap.tms ? UPD_DR : PA_DR;
      PA_DR:   state_d = tap.tms ? EX2_DR : PA_DR;
      EX2_DR:  state_d = tap.tms ? UPD_DR : SH_DR;
      UPD_DR:  state_d = tap.tms ? SEL_DR : RTI;
      SEL_IR:  state_d = tap.tms ? TLR    : CAP_IR;
      CAP_IR:  state_d = tap.tms ? EX1_IR : SH_IR;
      SH_IR:   state_d = tap.tms ? EX1_IR : SH_IR;
      EX1_IR:  state_d = tap.tms ? UPD_IR : PA_IR;
      PA_IR:   state_d = tap.tms ? EX2_IR : PA_IR;
      EX2_IR:  state_d = tap.tms ? UPD_IR : SH_IR;
      UPD_IR:  state_d = tap.tms ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  // Register next values; any edge landing in TLR reloads the reset values.
  always_comb begin
    ir_shift_d = ir_shift_q;
    instr_d    = instr_q;
    mode_d     = mode_q;
    bypass_d   = bypass_q;
    idcode_d   = idcode_q;
    case (state_q)
      CAP_IR: ir_shift_d = IR_CAPTURE;
      SH_IR:  ir_shift_d = {tap.tdi, ir_shift_q[IR_W-1:1]};
      UPD_IR: begin
        instr_d = ir_shift_q;
        mode_d  = (ir_shift_q == OP_EXTEST);
      end
      CAP_DR: begin
        if (sel_byp) bypass_d = 1'b0;
        if (sel_id)  idcode_d = IDCODE_VAL;
      end
      SH_DR: begin
        if (sel_byp) bypass_d = tap.tdi;
        if (sel_id)  idcode_d = {tap.tdi, idcode_q[31:1]};
      end
      default: ;
    endcase
    if (state_d == TLR) begin
      ir_shift_d = IR_CAPTURE;
      instr_d    = OP_IDCODE;
      mode_d     = 1'b0;
      bypass_d   = 1'b0;
      idcode_d   = IDCODE_VAL;
    end
  end

  // Rising-edge state: FSM, IR stages, mode and data registers.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      state_q    <= TLR;
      ir_shift_q <= IR_CAPTURE;
      instr_q    <= OP_IDCODE;
      mode_q     <= 1'b0;
      bypass_q   <= 1'b0;
      idcode_q   <= IDCODE_VAL;
    end else begin
      state_q    <= state_d;
      ir_shift_q <= ir_shift_d;
      instr_q    <= instr_d;
      mode_q     <= mode_d;
      bypass_q   <= bypass_d;
      idcode_q   <= idcode_d;
    end
  end

  // TDO source for the current state.
  always_comb begin
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    if (state_q == SH_IR) begin
      tdo_d    = ir_shift_q[0];
      tdo_en_d = 1'b1;
    end else if (state_q == SH_DR) begin
      tdo_en_d = 1'b1;
      if (sel_bsr)     tdo_d = tap.bsr_tdo;
      else if (sel_id) tdo_d = idcode_q[0];
      else             tdo_d = bypass_q;
    end
  end

  // TDO is launched on the falling edge so it is stable at the host's rising edge.
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign tap.tdo         = tdo_q;
  assign tap.tdo_en      = tdo_en_q;
  assign tap.bsr_tdi     = tap.tdi;
  assign tap.bsr_capture = sel_bsr && (state_q == CAP_DR);
  assign tap.bsr_shift   = sel_bsr && (state_q == SH_DR);
  assign tap.bsr_update  = sel_bsr && (state_q == UPD_DR);
  assign tap.bsr_mode    = mode_q;

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller: directed vector table, multi-cycle
// corner sequences and randomized pin activity against a behavioural model.
module tb_tap_controller;
  localparam int          IR_W = 4;
  localparam logic [31:0] IDV  = 32'h1000_0001;

  // Model state indices in the order the states are listed for the TAP.
  localparam int TLR = 0, RTI = 1, SEL_DR = 2, CAP_DR = 3, SH_DR = 4, EX1_DR = 5,
                 PA_DR = 6, EX2_DR = 7, UPD_DR = 8, SEL_IR = 9, CAP_IR = 10,
                 SH_IR = 11, EX1_IR = 12, PA_IR = 13, EX2_IR = 14, UPD_IR = 15;

  // Next state per state, indexed by tms.
  int nxt [16][2] = '{
    '{RTI, TLR}, '{RTI, SEL_DR}, '{CAP_DR, SEL_IR}, '{SH_DR, EX1_DR},
    '{SH_DR, EX1_DR}, '{PA_DR, UPD_DR}, '{PA_DR, EX2_DR}, '{SH_DR, UPD_DR},
    '{RTI, SEL_DR}, '{CAP_IR, TLR}, '{SH_IR, EX1_IR}, '{SH_IR, EX1_IR},
    '{PA_IR, UPD_IR}, '{PA_IR, EX2_IR}, '{SH_IR, UPD_IR}, '{RTI, SEL_DR}
  };

  logic tck = 1'b0;
  logic trst;

  tap_controller_if tap_if ();

  tap_controller dut (
    .tck  (tck),
    .trst (trst),
    .tap  (tap_if)
  );

  always #5 tck = ~tck;

  int tests = 0;
  int fails = 0;
  int cnt_cap, cnt_sh, cnt_upd;

  int              m_state;
  logic [IR_W-1:0] m_irs, m_ira;
  logic            m_mode, m_byp;
  logic [31:0]     m_idc;

  typedef struct packed {
    logic       tms;
    logic       tdi;
    logic       btdo;
    logic [5:0] exp;   // {tdo, tdo_en, capture, shift, update, mode}
  } vec_t;

  vec_t vecs [37];

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void model_reset();
    m_state = TLR;
    m_irs   = IR_W'(1);
    m_ira   = IR_W'(2);
    m_mode  = 1'b0;
    m_byp   = 1'b0;
    m_idc   = IDV;
  endfunction

  // One rising edge of the reference TAP.
  function automatic void model_edge(input logic tms_v, input logic tdi_v);
    int s;
    s = m_state;
    if (s == CAP_IR) m_irs = IR_W'(1);
    if (s == SH_IR)  m_irs = (m_irs >> 1) | (IR_W'(tdi_v) << (IR_W - 1));
    if (s == UPD_IR) begin
      m_ira  = m_irs;
      m_mode = (m_irs == IR_W'(0));
    end
    if (s == CAP_DR) begin
      m_byp = 1'b0;
      m_idc = IDV;
    end
    if (s == SH_DR) begin
      m_byp = tdi_v;
      m_idc = (m_idc >> 1) | (32'(tdi_v) << 31);
    end
    m_state = nxt[s][tms_v ? 1 : 0];
    if (m_state == TLR) model_reset();
  endfunction

  function automatic logic [6:0] model_out(input logic tdi_v, input logic btdo_v);
    logic bsr, en, d;
    bsr = (m_ira == IR_W'(0)) || (m_ira == IR_W'(1));
    en  = (m_state == SH_IR) || (m_state == SH_DR);
    d   = 1'b0;
    if (m_state == SH_IR)      d = m_irs[0];
    else if (m_state == SH_DR) d = bsr ? btdo_v : ((m_ira == IR_W'(2)) ? m_idc[0] : m_byp);
    return {d, en, bsr && (m_state == CAP_DR), bsr && (m_state == SH_DR),
            bsr && (m_state == UPD_DR), m_mode, tdi_v};
  endfunction

  function automatic logic [6:0] dut_out();
    return {tap_if.tdo, tap_if.tdo_en, tap_if.bsr_capture, tap_if.bsr_shift,
            tap_if.bsr_update, tap_if.bsr_mode, tap_if.bsr_tdi};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive pins away from the rising edge, clock once, sample after the falling edge.
  task automatic tick(input logic tms_v, input logic tdi_v, input logic btdo_v);
    tap_if.tms     = tms_v;
    tap_if.tdi     = tdi_v;
    tap_if.bsr_tdo = btdo_v;
    @(posedge tck);
    model_edge(tms_v, tdi_v);
    @(negedge tck);
    #1;
    check($sformatf("model st=%0d", m_state), 32'(dut_out()), 32'(model_out(tdi_v, btdo_v)));
    cnt_cap += (tap_if.bsr_capture === 1'b1) ? 1 : 0;
    cnt_sh  += (tap_if.bsr_shift   === 1'b1) ? 1 : 0;
    cnt_upd += (tap_if.bsr_update  === 1'b1) ? 1 : 0;
  endtask

  task automatic async_reset();
    logic [6:0] o;
    trst = 1'b0;
    #1;
    model_reset();
    o = dut_out();
    check("trst_immediate", 32'(o[6:1]), 32'd0);
    @(posedge tck);
    @(negedge tck);
    #1;
    o = dut_out();
    check("trst_held", 32'(o[6:1]), 32'd0);
    trst = 1'b1;
  endtask

  task automatic go_idle();
    repeat (5) tick(1'b1, rb(), rb());
    tick(1'b0, rb(), rb());
  endtask

  task automatic load_ir(input logic [IR_W-1:0] op);
    tick(1'b1, 1'b0, rb());
    tick(1'b1, 1'b0, rb());
    tick(1'b0, 1'b0, rb());
    tick(1'b0, 1'b0, rb());
    for (int i = 0; i < IR_W; i++) tick(i == IR_W - 1, op[i], rb());
    tick(1'b1, 1'b0, rb());
    tick(1'b0, 1'b0, rb());
    $display("[TB] IR load %b, bsr_mode=%b", op, tap_if.bsr_mode);
  endtask

  // DR scan of n bits from RTI, optionally pausing 3 cycles before bit pause_at.
  task automatic scan_dr(input int n, input int pause_at, output logic [31:0] data,
                         output int gaps);
    data = '0;
    gaps = 0;
    tick(1'b1, rb(), rb());
    tick(1'b0, rb(), rb());
    tick(1'b0, rb(), rb());
    data[0] = tap_if.tdo;
    if (tap_if.tdo_en !== 1'b1) gaps++;
    for (int i = 1; i < n; i++) begin
      if (i == pause_at) begin
        tick(1'b1, rb(), rb());
        repeat (3) tick(1'b0, rb(), rb());
        tick(1'b1, rb(), rb());
        tick(1'b0, rb(), rb());
      end else begin
        tick(1'b0, rb(), rb());
      end
      data[i] = tap_if.tdo;
      if (tap_if.tdo_en !== 1'b1) gaps++;
    end
    tick(1'b1, rb(), rb());
    tick(1'b1, rb(), rb());
    tick(1'b0, rb(), rb());
    $display("[TB] DR scan %0d bits (pause at %0d): %h", n, pause_at, data);
  endtask

  initial begin
    logic [6:0]  o;
    logic [31:0] data;
    int          gaps;
    logic        b;

    vecs = '{
      // IR scan of EXTEST from TLR
      '{1'b0, 1'b0, 1'b1, 6'b000000}, '{1'b1, 1'b0, 1'b1, 6'b000000},
      '{1'b1, 1'b0, 1'b1, 6'b000000}, '{1'b0, 1'b0, 1'b1, 6'b000000},
      '{1'b0, 1'b0, 1'b1, 6'b110000}, '{1'b0, 1'b0, 1'b1, 6'b010000},
      '{1'b0, 1'b0, 1'b1, 6'b010000}, '{1'b0, 1'b0, 1'b1, 6'b010000},
      '{1'b1, 1'b0, 1'b1, 6'b000000}, '{1'b1, 1'b0, 1'b1, 6'b000000},
      '{1'b0, 1'b0, 1'b1, 6'b000001},
      // EXTEST DR scan: strobes, tdo follows bsr_tdo
      '{1'b1, 1'b0, 1'b1, 6'b000001}, '{1'b0, 1'b0, 1'b1, 6'b001001},
      '{1'b0, 1'b0, 1'b1, 6'b110101}, '{1'b0, 1'b0, 1'b0, 6'b010101},
      '{1'b1, 1'b0, 1'b1, 6'b000001}, '{1'b1, 1'b0, 1'b1, 6'b000011},
      '{1'b0, 1'b0, 1'b1, 6'b000001},
      // IR scan of BYPASS (1111)
      '{1'b1, 1'b0, 1'b1, 6'b000001}, '{1'b1, 1'b0, 1'b1, 6'b000001},
      '{1'b0, 1'b0, 1'b1, 6'b000001}, '{1'b0, 1'b1, 1'b1, 6'b110001},
      '{1'b0, 1'b1, 1'b1, 6'b010001}, '{1'b0, 1'b1, 1'b1, 6'b010001},
      '{1'b0, 1'b1, 1'b1, 6'b010001}, '{1'b1, 1'b1, 1'b1, 6'b000001},
      '{1'b1, 1'b1, 1'b1, 6'b000001}, '{1'b0, 1'b0, 1'b1, 6'b000000},
      // BYPASS DR scan: tdi 1,0,1,1 returns 0,1,0,1, no strobes
      '{1'b1, 1'b0, 1'b1, 6'b000000}, '{1'b0, 1'b0, 1'b1, 6'b000000},
      '{1'b0, 1'b0, 1'b1, 6'b010000}, '{1'b0, 1'b1, 1'b1, 6'b110000},
      '{1'b0, 1'b0, 1'b1, 6'b010000}, '{1'b0, 1'b1, 1'b1, 6'b110000},
      '{1'b1, 1'b1, 1'b1, 6'b000000}, '{1'b1, 1'b0, 1'b1, 6'b000000},
      '{1'b0, 1'b0, 1'b1, 6'b000000}
    };

    cnt_cap = 0;
    cnt_sh  = 0;
    cnt_upd = 0;
    tap_if.tms     = 1'b0;
    tap_if.tdi     = 1'b0;
    tap_if.bsr_tdo = 1'b0;
    trst = 1'b0;
    model_reset();
    repeat (2) @(negedge tck);
    #1;
    o = dut_out();
    check("reset_outputs", 32'(o[6:1]), 32'd0);
    trst = 1'b1;

    // Directed vector table
    for (int k = 0; k < 37; k++) begin
      tick(vecs[k].tms, vecs[k].tdi, vecs[k].btdo);
      o = dut_out();
      check($sformatf("vec%0d", k), 32'(o[6:1]), 32'(vecs[k].exp));
    end
    $display("[TB] vector table applied (%0d rows)", 37);

    // trst asserted mid-shift with EXTEST active
    load_ir(IR_W'(0));
    check("extest_mode", 32'(tap_if.bsr_mode), 32'd1);
    tick(1'b1, 1'b0, rb());
    tick(1'b0, 1'b0, rb());
    repeat (3) tick(1'b0, rb(), rb());
    async_reset();
    $display("[TB] trst pulse mid-SH_DR");
    tick(1'b0, 1'b0, rb());
    scan_dr(32, -1, data, gaps);
    check("idcode_after_trst", data, IDV);

    // Five tms=1 edges from PA_IR
    load_ir(IR_W'(0));
    tick(1'b1, 1'b0, rb());
    tick(1'b1, 1'b0, rb());
    tick(1'b0, 1'b0, rb());
    tick(1'b0, 1'b0, rb());
    tick(1'b1, rb(), rb());
    tick(1'b0, rb(), rb());
    cnt_upd = 0;
    repeat (5) tick(1'b1, rb(), rb());
    $display("[TB] tms reset from PA_IR");
    check("tms_reset_no_update", 32'(cnt_upd), 32'd0);
    check("tms_reset_mode", 32'(tap_if.bsr_mode), 32'd0);
    tick(1'b0, 1'b0, rb());
    scan_dr(32, -1, data, gaps);
    check("idcode_after_tms", data, IDV);

    // SAMPLE: 5-bit BSR scan, tdo mirrors bsr_tdo
    load_ir(IR_W'(1));
    cnt_cap = 0;
    cnt_sh  = 0;
    cnt_upd = 0;
    tick(1'b1, rb(), rb());
    tick(1'b0, rb(), rb());
    for (int i = 0; i < 5; i++) begin
      b = rb();
      tick(1'b0, rb(), b);
      check($sformatf("sample_tdo%0d", i), 32'(tap_if.tdo), 32'(b));
    end
    tick(1'b1, rb(), rb());
    tick(1'b1, rb(), rb());
    tick(1'b0, rb(), rb());
    $display("[TB] SAMPLE scan: cap=%0d sh=%0d upd=%0d", cnt_cap, cnt_sh, cnt_upd);
    check("sample_capture", 32'(cnt_cap), 32'd1);
    check("sample_shift", 32'(cnt_sh), 32'd5);
    check("sample_update", 32'(cnt_upd), 32'd1);
    check("sample_mode", 32'(tap_if.bsr_mode), 32'd0);

    // IDCODE scan paused after 10 bits
    go_idle();
    scan_dr(32, 10, data, gaps);
    check("idcode_paused", data, IDV);
    check("idcode_paused_gaps", 32'(gaps), 32'd0);

    // Randomized pin activity against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 249) == 0) async_reset();
      else tick($urandom_range(0, 99) < 30, rb(), rb());
    end
    $display("[TB] random phase done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tap_controller.md
# tap_controller

IEEE 1149.1 TAP controller that sequences the boundary-scan register chain and the full-adder test datapath from the JTAG pins. It contains the 16-state TAP FSM, the instruction register and its decode, the bypass and IDCODE data registers, and the TDO output mux. It generates the capture, shift and update strobes and the mode select for the `bsr_cell` chain, and receives the chain's serial output back.

## Interface
- `IR_W`, 4: instruction register width (≥2).
- `IDCODE_VAL`, 32'h1000_0001: value captured into IDCODE DR; bit 0 must be 1.
- `OP_EXTEST`, 4'b0000: EXTEST opcode.
- `OP_SAMPLE`, 4'b0001: SAMPLE/PRELOAD opcode.
- `OP_IDCODE`, 4'b0010: IDCODE opcode.
- All-ones opcode is BYPASS. Every undefined opcode also decodes as BYPASS.

Ports:
- `tck` in 1: test clock, the only clock. All state updates on rising edge; `tdo`/`tdo_en` update on falling edge.
- `trst` in 1: asynchronous, active-low reset.
- `tms` in 1: mode select, sampled on rising `tck`.
- `tdi` in 1: serial data in.
- `tdo` out 1: serial data out.
- `tdo_en` out 1: high while `tdo` is valid (Shift-DR/Shift-IR).
- `bsr_tdi` out 1: serial input to the BSR chain (`= tdi`).
- `bsr_capture` out 1: BSR cells load their parallel inputs this rising edge.
- `bsr_shift` out 1: BSR cells shift this rising edge.
- `bsr_update` out 1: BSR cells transfer shift stage to update stage this rising edge.
- `bsr_mode` out 1: 1 means cells drive update-stage values (test mode); 0 means functional passthrough.
- `bsr_tdo` in 1: serial output of the last BSR cell.

## Operation
- **FSM states:** TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR.
- **FSM transitions** (tms=0 / tms=1):
  - TLR→RTI/TLR
  - RTI→RTI/SEL_DR
  - SEL_DR→CAP_DR/SEL_IR
  - SEL_IR→CAP_IR/TLR
  - CAP_x→SH_x/EX1_x
  - SH_x→SH_x/EX1_x
  - EX1_x→PA_x/UPD_x
  - PA_x→PA_x/EX2_x
  - EX2_x→SH_x/UPD_x
  - UPD_x→RTI/SEL_DR
- From any state, 5 consecutive `tms`=1 edges reach TLR.
- **IR shift stage:**
  - CAP_IR loads {0…0,01}.
  - SH_IR shifts right: `tdi`→MSB, LSB→`tdo`.
- **Active instruction:**
  - Loaded from the shift stage on the rising edge that leaves UPD_IR.
  - Forced to IDCODE in TLR.
- **DR selection by active instruction:**
  - EXTEST and SAMPLE select the BSR.
  - IDCODE selects the 32-bit IDCODE register.
  - BYPASS selects the 1-bit bypass register.
- **Bypass register:** cleared in CAP_DR; takes `tdi` in SH_DR.
- **IDCODE register:** loads `IDCODE_VAL` in CAP_DR; shifts right in SH_DR with `tdi`→bit 31.
- **BSR strobes** (combinational from the current state, gated by BSR selected): `bsr_capture`=CAP_DR, `bsr_shift`=SH_DR, `bsr_update`=UPD_DR. None of them assert in any other state or for any other instruction.
- **`bsr_mode`:** 1 iff the active instruction is EXTEST. Registered, changes only on the UPD_IR exit edge or on reset.
- **TDO mux:**
  - SH_IR selects IR LSB.
  - SH_DR selects the selected DR's LSB, or `bsr_tdo`.
  - Otherwise `tdo`=0 and `tdo_en`=0.
- **Reset values:**
  - State: TLR.
  - IR shift stage: {0…0,01}.
  - Active instruction: IDCODE.
  - `bsr_mode`: 0.
  - Bypass register: 0.
  - IDCODE register: `IDCODE_VAL`.
  - `tdo`: 0; `tdo_en`: 0.
  - Strobes: 0 (they follow from state TLR).

## Timing
- **FSM:** next state on rising `tck` from `tms`; no other latency.
- **`tdo`/`tdo_en`:** registered on falling `tck` from the mux value for the current state. The first shifted bit appears on the falling edge after entering SH_x.
- **Shift length:** N rising edges in SH_x shift N bits. The last bit is shifted on the SH_x→EX1_x edge, which also counts as a shift.
- **Asynchronous reset:** `trst` low sets all reset values immediately, including mid-shift. The IR is not updated and no `bsr_update` is generated. Release is sampled at the next rising `tck`.
- **Reset and TLR:** TLR entry via `tms` has the same register effect as reset, except that `tdo` follows the falling edge.
- **Paused scans:** PA_x holds every shift register; EX2→SH resumes without loss.

## Test plan
- **Reset:** assert `trst`=0 mid-SH_DR with EXTEST active, then release. Expect state TLR, `bsr_mode`=0, `tdo_en`=0. A DR scan of 32 bits returns 32'h1000_0001, LSB first.
- **TMS reset:** from PA_IR, apply 5 edges of `tms`=1. Expect TLR, with no `bsr_update` pulse in between.
- **IR scan EXTEST:** shift 4'b0000. `tdo` returns 1,0,0,0 (the captured 01 pattern). `bsr_mode` rises on the UPD_IR exit edge.
- **BYPASS:** load 4'b1111, then in SH_DR shift `tdi`=1,0,1,1. Expect `tdo`=0,1,0,1 (one-bit delay). No BSR strobe asserts.
- **SAMPLE DR scan:** 5 shift cycles. Expect `bsr_capture` for exactly 1 cycle in CAP_DR, `bsr_shift` for 5 cycles, `bsr_update` for 1 cycle in UPD_DR. `tdo` mirrors `bsr_tdo`. `bsr_mode` stays 0.
- **Pause:** during an IDCODE shift, pause after 10 bits for 3 cycles, then resume. The remaining 22 bits continue without gaps and the full IDCODE is read intact.
